async_fifo_wr_ctrl: RTL

ASYNC_FIFO_WR_CTRL -- requirements
Module: async_fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/ptr_sync.sv | 36 +++
 rtl/async_fifo_wr_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion and
// pointer sizing, so both clock domains encode pointers identically.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int ptr_width(input int depth_w);
    return depth_w + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// N-stage synchronizer for a Gray-coded pointer crossing into the local clock.
// Only one bit changes per step, so every captured value is a valid pointer.
module ptr_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  always_comb begin
    sync_d    = '{default: '0};
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: drives the RAM write port with
// zero latency and derives full/almost_full/level from the synced read pointer.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RAM_DEPTH   = 256,
  parameter int DEPTH_W     = $clog2(RAM_DEPTH),
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 4
) (
  input  logic               clk_a,
  input  logic               rst_b,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  output logic               wea,
  output logic [DEPTH_W-1:0] addra,
  output logic [DATA_W-1:0]  dina,
  output logic [DEPTH_W:0]   wptr_gray,
  input  logic [DEPTH_W:0]   rptr_gray_async,
  output logic               full,
  output logic               almost_full,
  output logic [DEPTH_W:0]   wr_level,
  input  logic               ovf_clr,
  output logic               overflow
);

  localparam int PTR_W = ptr_width(DEPTH_W);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(RAM_DEPTH);
  localparam logic [PTR_W-1:0] AF_P    = PTR_W'(AF_THRESH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wptr_gray_q, wptr_gray_d;
  logic [PTR_W-1:0] wr_level_q, wr_level_d;
  logic             full_q, full_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] rgray_s;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] rgray_full;
  logic             accept;

  ptr_sync #(
    .W      (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (clk_a),
    .rst_b (rst_b),
    .d     (rptr_gray_async),
    .q     (rgray_s)
  );

  assign rbin_s     = PTR_W'(gray2bin(PTR_MAX_W'(rgray_s)));
  // Full when the write pointer has lapped the read pointer by one whole buffer.
  assign rgray_full = {~rgray_s[PTR_W-1:PTR_W-2], rgray_s[PTR_W-3:0]};

  // Gating with rst_b kills an in-flight write the moment reset asserts.
  assign s_ready = ~full_q & ~rst_b;
  assign accept  = s_valid & s_ready;
  assign wea     = accept;
  assign addra   = wbin_q[DEPTH_W-1:0];
  assign dina    = s_data;

  always_comb begin
    wbin_d        = wbin_q + PTR_W'(accept);
    wptr_gray_d   = PTR_W'(bin2gray(PTR_MAX_W'(wbin_d)));
    full_d        = (wptr_gray_d == rgray_full);
    wr_level_d    = wbin_d - rbin_s;
    almost_full_d = ((DEPTH_P - wr_level_d) <= AF_P);
    // Set wins over clear so a clear never hides a same-cycle overflow.
    overflow_d    = (overflow_q & ~ovf_clr) | (s_valid & full_q);
  end

  always_ff @(posedge clk_a or posedge rst_b) begin
    if (rst_b) begin
      wbin_q        <= '0;
      wptr_gray_q   <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_gray_q   <= wptr_gray_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wptr_gray   = wptr_gray_q;
  assign wr_level    = wr_level_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

endmodule
